pixel_batch_fifo: RTL

Downstream stage of `pixel_processor`. Captures each completed batch of `NUM_PIXELS` 12-bit pixels into a small batch FIFO and acknowledges it with `start_next_batch`. Serializes the buffered pixels, one per `pixel_request`, to the VGA output path. Decouples the fixed 16-cycle microcode batch cadence from the display pixel clock, flushes on `new_frame`, and flags underruns.

---
 rtl/pixel_pipe_pkg.sv | 20 ++
 rtl/pixel_batch_mem.sv | 28 ++
 rtl/pixel_batch_fifo.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/pixel_pipe_pkg.sv
// Shared pixel pipeline types: pixel/batch formats and the capture FSM state encoding.
// Used by pixel_batch_fifo (optional feature macro: PIXEL_FIFO_UNDERRUN_COUNT_EN).
package pixel_pipe_pkg;

  localparam int PIXEL_WIDTH = 12;
  localparam int NUM_PIXELS  = 8;

  typedef logic [PIXEL_WIDTH-1:0] pixel_t;
  typedef pixel_t [NUM_PIXELS-1:0] batch_t;

  typedef enum logic {
    WAIT = 1'b0,
    ACK  = 1'b1
  } cap_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/pixel_batch_mem.sv
// Batch storage for pixel_batch_fifo: DEPTH entries, one synchronous write port,
// one asynchronous read port presenting the head batch.
module pixel_batch_mem
  import pixel_pipe_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                              clk,
  input  logic                              wr_en,
  input  logic [AW-1:0]                     wr_addr,
  input  logic [NUM_PIXELS*PIXEL_WIDTH-1:0] wr_data,
  input  logic [AW-1:0]                     rd_addr,
  output logic [NUM_PIXELS*PIXEL_WIDTH-1:0] rd_data
);

  logic [NUM_PIXELS*PIXEL_WIDTH-1:0] mem_r [DEPTH];

  // write port: contents need no reset, only entries below count are ever read
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/pixel_batch_fifo.sv
// Batch FIFO between pixel_processor and the VGA path: captures whole batches,
// serializes one pixel per request, flushes on new_frame, flags underruns.
// Optional: define PIXEL_FIFO_UNDERRUN_COUNT_EN to add the underrun_count output.
module pixel_batch_fifo
  import pixel_pipe_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_PIXELS*PIXEL_WIDTH-1:0] batch_data,
  input  logic                              batch_ready,
  output logic                              start_next_batch,
  input  logic                              new_frame,
  input  logic                              pixel_request,
  output logic [PIXEL_WIDTH-1:0]            pixel_data,
  output logic                              underrun
`ifdef PIXEL_FIFO_UNDERRUN_COUNT_EN
  ,
  output logic [15:0]                       underrun_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(NUM_PIXELS);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_PIXELS - 1);

  cap_state_t                        state_r;
  cap_state_t                        state_nxt_s;
  logic [CW-1:0]                     count_r;
  logic [AW-1:0]                     wr_ptr_r;
  logic [AW-1:0]                     rd_ptr_r;
  logic [IW-1:0]                     pix_idx_r;
  logic [NUM_PIXELS*PIXEL_WIDTH-1:0] head_flat_s;
  batch_t                            head_s;
  logic                              full_s;
  logic                              empty_s;
  logic                              capture_s;
  logic                              serve_s;
  logic                              pop_s;
  logic                              empty_req_s;

  assign full_s  = (count_r == FULL_CNT);
  assign empty_s = (count_r == {CW{1'b0}});
  assign head_s  = batch_t'(head_flat_s);

  pixel_batch_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (capture_s),
    .wr_addr (wr_ptr_r),
    .wr_data (batch_data),
    .rd_addr (rd_ptr_r),
    .rd_data (head_flat_s)
  );

  // capture FSM: ACK masks the still-high batch_ready for one cycle after the write
  always_comb begin
    state_nxt_s = state_r;
    capture_s   = 1'b0;
    case (state_r)
      WAIT: begin
        if (batch_ready && !full_s && !new_frame) begin
          capture_s   = 1'b1;
          state_nxt_s = ACK;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      ACK:     state_nxt_s = WAIT;
      default: state_nxt_s = WAIT;
    endcase
  end

  // read-side qualifiers; new_frame turns any request into a silent black pixel
  always_comb begin
    serve_s     = pixel_request && !empty_s && !new_frame;
    pop_s       = serve_s && (pix_idx_r == LAST_IDX);
    empty_req_s = pixel_request && empty_s && !new_frame;
  end

  // FSM state and registered acknowledge (high exactly while in ACK)
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r          <= WAIT;
      start_next_batch <= 1'b0;
    end else begin
      state_r          <= state_nxt_s;
      start_next_batch <= capture_s;
    end
  end

  // pointers, occupancy and pixel index; no write/read bypass through count
  always_ff @(posedge clk) begin
    if (reset || new_frame) begin
      wr_ptr_r  <= {AW{1'b0}};
      rd_ptr_r  <= {AW{1'b0}};
      count_r   <= {CW{1'b0}};
      pix_idx_r <= {IW{1'b0}};
    end else begin
      if (capture_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      count_r <= count_r + CW'(capture_s) - CW'(pop_s);
      if (serve_s) begin
        pix_idx_r <= (pix_idx_r == LAST_IDX) ? {IW{1'b0}} : pix_idx_r + IW'(1);
      end
    end
  end

  // pixel output register and sticky underrun flag (survives new_frame)
  always_ff @(posedge clk) begin
    if (reset) begin
      pixel_data <= {PIXEL_WIDTH{1'b0}};
      underrun   <= 1'b0;
    end else begin
      if (pixel_request) begin
        pixel_data <= serve_s ? head_s[pix_idx_r] : {PIXEL_WIDTH{1'b0}};
      end
      if (empty_req_s) begin
        underrun <= 1'b1;
      end
    end
  end

`ifdef PIXEL_FIFO_UNDERRUN_COUNT_EN
  // saturating per-frame underrun counter
  always_ff @(posedge clk) begin
    if (reset || new_frame) begin
      underrun_count <= 16'd0;
    end else if (empty_req_s) begin
      underrun_count <= sat_inc16(underrun_count);
    end
  end
`endif

endmodule
